// File: rtl/pm_loader_pkg.sv
// Shared definitions for the program-memory boot loader.
package pm_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_RUN
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Word counts need one bit more than the widest address so 2^8 fits.
  localparam int CNT_W = 9;

  // A count byte of zero stands for a full memory of 2^pc_width words.
  function automatic logic [CNT_W-1:0] decode_count(input logic [7:0] b,
                                                    input int pc_width);
    logic [CNT_W-1:0] depth;
    depth = CNT_W'(1) << pc_width;
    return (b == 8'h00) ? depth : {1'b0, b};
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Clearable saturating idle counter; flags when TIMEOUT idle cycles have passed.
module loader_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TIMEOUT));

  // Count idle cycles, holding at TIMEOUT until cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pm_loader.sv
// Boot loader: parses A5/N/words/checksum frames into program memory and
// releases the core from reset only after a frame verifies.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int          PC_WIDTH = 6,
  parameter int          TIMEOUT  = 1000,
  parameter logic [7:0]  HEADER   = HEADER_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  input  logic                load_req,
  output logic                pm_we,
  output logic [PC_WIDTH-1:0] pm_addr,
  output logic [15:0]         pm_wdata,
  output logic                core_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << PC_WIDTH;

  state_t                state;
  logic [PC_WIDTH-1:0]   idx;
  logic [CNT_W-1:0]      n_words;
  logic [7:0]            checksum;
  logic                  accept;
  logic                  timing;
  logic                  expired;
  logic                  last_word;
  logic [CNT_W-1:0]      n_decoded;

  assign in_ready  = (state inside {S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK});
  assign accept    = in_valid && in_ready;
  assign timing    = (state inside {S_COUNT, S_HI, S_LO, S_CHECK});
  assign n_decoded = decode_count(in_data, PC_WIDTH);
  assign last_word = (CNT_W'(idx) == (n_words - 1'b1));

  // Idle time only accumulates while a frame is open and no byte arrives.
  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept || !timing),
    .enable  (timing && !accept),
    .expired (expired)
  );

  // Frame parser and core-reset sequencer with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b1;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      idx        <= '0;
      n_words    <= '0;
      checksum   <= '0;
    end else begin
      pm_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && in_data == HEADER) begin
            state    <= S_COUNT;
            error    <= 1'b0;
            checksum <= '0;
            idx      <= '0;
            busy     <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (n_decoded > DEPTH) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              n_words <= n_decoded;
              state   <= S_HI;
            end
          end else if (expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_HI: begin
          if (accept) begin
            pm_wdata[15:8] <= in_data;
            checksum       <= checksum ^ in_data;
            state          <= S_LO;
          end else if (expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_LO: begin
          if (accept) begin
            pm_wdata[7:0] <= in_data;
            checksum      <= checksum ^ in_data;
            pm_we         <= 1'b1;
            pm_addr       <= idx;
            state         <= S_WRITE;
          end else if (expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (last_word) begin
            state <= S_CHECK;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_HI;
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (in_data == checksum) begin
              state      <= S_RUN;
              core_reset <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (load_req) begin
            state      <= S_IDLE;
            core_reset <= 1'b1;
            done       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: directed frames, write scoreboard, status checks.
module tb_pm_loader;

  localparam int PCW = 6;
  localparam int TMO = 40;

  logic             clock    = 1'b0;
  logic             reset    = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data  = 8'h00;
  logic             load_req = 1'b0;
  logic             in_ready;
  logic             pm_we;
  logic [PCW-1:0]   pm_addr;
  logic [15:0]      pm_wdata;
  logic             core_reset;
  logic             busy;
  logic             done;
  logic             error;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [PCW-1:0] addr;
    logic [15:0]    data;
  } wr_t;

  wr_t exp_q[$];

  pm_loader #(
    .PC_WIDTH (PCW),
    .TIMEOUT  (TMO),
    .HEADER   (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_req   (load_req),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write monitor: every pm_we strobe must match the next queued write.
  always @(negedge clock) begin
    wr_t e;
    if (pm_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", pm_addr, pm_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(pm_addr), 32'(e.addr));
        chk("wr_data", 32'(pm_wdata), 32'(e.data));
      end
    end
  end

  task automatic push_wr(input int addr, input logic [15:0] data);
    wr_t e;
    e.addr = PCW'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_wait actual=0 required=1 byte=%0h", b);
    end else begin
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic reload();
    @(negedge clock);
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    chk("reload_core_reset", 32'(core_reset), 1);
    chk("reload_done", 32'(done), 0);
    chk("reload_ready", 32'(in_ready), 1);
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_core_reset"}, 32'(core_reset), 0);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_ready"}, 32'(in_ready), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cs;
    logic [15:0] w;

    // Reset values while reset is held.
    #12;
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_pm_we", 32'(pm_we), 0);
    chk("rst_pm_addr", 32'(pm_addr), 0);
    chk("rst_pm_wdata", 32'(pm_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(negedge clock);
    reset = 1'b1;

    // Good two-word frame.
    push_wr(0, 16'h1234);
    push_wr(1, 16'hABCD);
    send_byte(8'hA5);
    chk("good_busy", 32'(busy), 1);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("good_we_latency", 32'(pm_we), 1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("good_pre_check_core_reset", 32'(core_reset), 1);
    send_byte(8'h40);
    chk_run("good");
    reload();

    // Bad checksum: words still written, core stays in reset.
    push_wr(0, 16'h1234);
    push_wr(1, 16'hABCD);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h41);
    chk("bad_error", 32'(error), 1);
    chk("bad_core_reset", 32'(core_reset), 1);
    chk("bad_busy", 32'(busy), 0);
    chk("bad_done", 32'(done), 0);
    chk("bad_ready", 32'(in_ready), 1);

    // Noise ahead of the header is discarded.
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("noise_busy", 32'(busy), 0);
    send_byte(8'hA5);
    chk("noise_error_cleared", 32'(error), 0);
    push_wr(0, 16'h000F);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0F);
    send_byte(8'h0F);
    chk_run("noise");
    reload();

    // Full-depth frame: N=0 means 64 words, last write at 3F.
    cs = 8'h00;
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), 8'(i * 3 + 1)};
      cs = cs ^ w[15:8] ^ w[7:0];
      push_wr(i, w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    send_byte(cs);
    chk_run("full");
    reload();

    // Oversize count.
    send_byte(8'hA5);
    send_byte(8'h41);
    chk("over_error", 32'(error), 1);
    chk("over_busy", 32'(busy), 0);
    chk("over_ready", 32'(in_ready), 1);
    repeat (3) @(negedge clock);

    // Timeout after the HI byte.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TMO) @(negedge clock);
    chk("tmo_not_early_error", 32'(error), 0);
    chk("tmo_not_early_busy", 32'(busy), 1);
    @(negedge clock);
    chk("tmo_error", 32'(error), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_ready", 32'(in_ready), 1);
    send_byte(8'hA5);
    chk("tmo_error_cleared", 32'(error), 0);
    chk("tmo_rehdr_busy", 32'(busy), 1);

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h01);
    send_byte(8'h55);
    chk("midrst_pre_wdata", 32'(pm_wdata[15:8]), 32'h55);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_wdata", 32'(pm_wdata), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_core_reset", 32'(core_reset), 1);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_addr", 32'(pm_addr), 0);
    @(negedge clock);
    reset = 1'b1;

    // Recovery frame after the reset.
    push_wr(0, 16'h000F);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0F);
    send_byte(8'h0F);
    chk_run("recover");

    repeat (4) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
